snitch_hwloop_setup_ctrl: RTL and testbench

Sequencer in front of the Snitch hardware-loop register unit. It accepts loop-setup commands from the decoder over a valid/ready handshake and computes start/end addresses from PC plus offset. It then drives the loop unit's start/end/count write ports in a fixed order, so a loop is only armed once both addresses are valid. It also keeps a per-loop shadow iteration count and reports which loops are active.

---
 rtl/snitch_hwloop_pkg.sv | 21 ++
 rtl/snitch_hwloop_shadow_cnt.sv | 36 +++
 rtl/snitch_hwloop_setup_ctrl.sv | 129 ++++++++++++
 tb/tb_snitch_hwloop_setup_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snitch_hwloop_pkg.sv
// Shared opcodes, sequencer states and constants for the
// hardware-loop setup path.
package snitch_hwloop_pkg;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_END   = 2'd1,
        OP_COUNT = 2'd2,
        OP_SETUP = 2'd3
    } hwloop_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_START = 2'd1,
        WR_END   = 2'd2,
        WR_CNT   = 2'd3
    } hwloop_state_e;

    localparam logic [31:0] HWLOOP_INSN_BYTES = 32'd4;

endpackage

// File: rtl/snitch_hwloop_shadow_cnt.sv
// Per-loop shadow iteration counters; a load beats a decrement and
// decrements saturate at zero.
module snitch_hwloop_shadow_cnt #(
    parameter int unsigned N_HW_LOOPS = 2,
    parameter int unsigned N_REG_BITS = $clog2(N_HW_LOOPS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_load,
    input  logic [N_REG_BITS-1:0] i_regid,
    input  logic [31:0]           i_data,
    input  logic [N_HW_LOOPS-1:0] i_dec,
    output logic [N_HW_LOOPS-1:0] o_active
);

    logic [31:0] r_cnt [N_HW_LOOPS];

    for (genvar l = 0; l < N_HW_LOOPS; l++) begin : g_loop
        logic w_hit;

        assign w_hit = i_load && (i_regid == N_REG_BITS'(l));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_cnt[l] <= '0;
            end else if (w_hit) begin
                r_cnt[l] <= i_data;
            end else if (i_dec[l] && (r_cnt[l] != '0)) begin
                r_cnt[l] <= r_cnt[l] - 32'd1;
            end
        end

        assign o_active[l] = (r_cnt[l] != '0);
    end

endmodule

// File: rtl/snitch_hwloop_setup_ctrl.sv
// Hardware-loop setup sequencer: turns decoder commands into ordered
// start/end/count writes to the loop register unit.
module snitch_hwloop_setup_ctrl
    import snitch_hwloop_pkg::*;
#(
    parameter int unsigned N_HW_LOOPS = 2,
    parameter int unsigned N_REG_BITS = $clog2(N_HW_LOOPS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [N_REG_BITS-1:0] req_regid_i,
    input  logic [31:0]           req_pc_i,
    input  logic [31:0]           req_imm_i,
    input  logic [31:0]           req_cnt_i,
    input  logic                  flush_i,
    output logic [N_REG_BITS-1:0] hwloop_regid_o,
    output logic [31:0]           hwloop_start_address_o,
    output logic [31:0]           hwloop_end_address_o,
    output logic [31:0]           hwloop_cnt_data_o,
    output logic                  hwloop_we_start_o,
    output logic                  hwloop_we_end_o,
    output logic                  hwloop_we_count_o,
    input  logic [N_HW_LOOPS-1:0] hwloop_dec_i,
    output logic [N_HW_LOOPS-1:0] loop_active_o,
    output logic                  busy_o
);

    hwloop_state_e         r_state;
    hwloop_state_e         w_state_nxt;
    hwloop_op_e            r_op;
    hwloop_op_e            w_op;
    logic [N_REG_BITS-1:0] r_regid;
    logic [31:0]           r_start;
    logic [31:0]           r_end;
    logic [31:0]           r_cnt;
    logic [31:0]           w_target;
    logic                  w_accept;

    assign w_op     = hwloop_op_e'(req_op_i);
    assign w_target = req_pc_i + req_imm_i;
    assign w_accept = req_valid_i && (r_state == IDLE) && !flush_i;

    always_comb begin
        w_state_nxt       = r_state;
        req_ready_o       = 1'b0;
        hwloop_we_start_o = 1'b0;
        hwloop_we_end_o   = 1'b0;
        hwloop_we_count_o = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (w_accept) begin
                    case (w_op)
                        OP_END:   w_state_nxt = WR_END;
                        OP_COUNT: w_state_nxt = WR_CNT;
                        default:  w_state_nxt = WR_START;
                    endcase
                end
            end
            WR_START: begin
                hwloop_we_start_o = 1'b1;
                w_state_nxt = (r_op == OP_SETUP) ? WR_END : IDLE;
            end
            WR_END: begin
                hwloop_we_end_o = 1'b1;
                w_state_nxt = (r_op == OP_END) ? IDLE : WR_CNT;
            end
            WR_CNT: begin
                hwloop_we_count_o = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // An enable decoded this cycle still goes out; only later ones die.
        if (flush_i) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op    <= OP_START;
            r_regid <= '0;
            r_start <= '0;
            r_end   <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_op    <= w_op;
            r_regid <= req_regid_i;
            unique case (w_op)
                OP_START: r_start <= w_target;
                OP_END:   r_end   <= w_target;
                OP_COUNT: r_cnt   <= req_cnt_i;
                OP_SETUP: begin
                    r_start <= req_pc_i + HWLOOP_INSN_BYTES;
                    r_end   <= w_target;
                    r_cnt   <= req_cnt_i;
                end
                default: ;
            endcase
        end
    end

    assign hwloop_regid_o         = r_regid;
    assign hwloop_start_address_o = r_start;
    assign hwloop_end_address_o   = r_end;
    assign hwloop_cnt_data_o      = r_cnt;
    assign busy_o                 = !req_ready_o;

    snitch_hwloop_shadow_cnt #(
        .N_HW_LOOPS (N_HW_LOOPS),
        .N_REG_BITS (N_REG_BITS)
    ) i_shadow (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_load   (hwloop_we_count_o),
        .i_regid  (r_regid),
        .i_data   (r_cnt),
        .i_dec    (hwloop_dec_i),
        .o_active (loop_active_o)
    );

endmodule

// File: tb/tb_snitch_hwloop_setup_ctrl.sv
// Scoreboard bench for the hardware-loop setup sequencer: a command-level
// model queues expected writes, a monitor compares every cycle.
module tb_snitch_hwloop_setup_ctrl;
    import snitch_hwloop_pkg::*;

    localparam int NL = 2;
    localparam int RB = $clog2(NL);

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [1:0]    req_op_i = '0;
    logic [RB-1:0] req_regid_i = '0;
    logic [31:0]   req_pc_i = '0;
    logic [31:0]   req_imm_i = '0;
    logic [31:0]   req_cnt_i = '0;
    logic          flush_i = 1'b0;
    logic [RB-1:0] hwloop_regid_o;
    logic [31:0]   hwloop_start_address_o;
    logic [31:0]   hwloop_end_address_o;
    logic [31:0]   hwloop_cnt_data_o;
    logic          hwloop_we_start_o;
    logic          hwloop_we_end_o;
    logic          hwloop_we_count_o;
    logic [NL-1:0] hwloop_dec_i;
    logic [NL-1:0] loop_active_o;
    logic          busy_o;

    logic [NL-1:0] dec_rnd = '0;
    logic [NL-1:0] dec_dir = '0;
    assign hwloop_dec_i = dec_rnd | dec_dir;

    snitch_hwloop_setup_ctrl #(.N_HW_LOOPS(NL)) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .req_valid_i            (req_valid_i),
        .req_ready_o            (req_ready_o),
        .req_op_i               (req_op_i),
        .req_regid_i            (req_regid_i),
        .req_pc_i               (req_pc_i),
        .req_imm_i              (req_imm_i),
        .req_cnt_i              (req_cnt_i),
        .flush_i                (flush_i),
        .hwloop_regid_o         (hwloop_regid_o),
        .hwloop_start_address_o (hwloop_start_address_o),
        .hwloop_end_address_o   (hwloop_end_address_o),
        .hwloop_cnt_data_o      (hwloop_cnt_data_o),
        .hwloop_we_start_o      (hwloop_we_start_o),
        .hwloop_we_end_o        (hwloop_we_end_o),
        .hwloop_we_count_o      (hwloop_we_count_o),
        .hwloop_dec_i           (hwloop_dec_i),
        .loop_active_o          (loop_active_o),
        .busy_o                 (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // kind: 0 start, 1 end, 2 count
    typedef struct {
        int          kind;
        int          regid;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         q[$];
    int          cyc;
    int          ready_at = 0;
    int          m_regid = 0;
    logic [31:0] m_start = '0;
    logic [31:0] m_end = '0;
    logic [31:0] m_cnt = '0;
    logic [31:0] sh [NL];
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;
    bit          dec_en = 1'b0;

    wr_t           mon_it;
    logic [2:0]    mon_we;
    int            mon_ld;
    logic [NL-1:0] mon_act;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    always @(posedge clk_i) begin
        #1;
        if (dec_en && $urandom_range(0, 3) == 0)
            dec_rnd = NL'(1) << $urandom_range(0, NL - 1);
        else
            dec_rnd = '0;
    end

    // Monitor: compares outputs each cycle, pops writes due this cycle,
    // then advances the shadow-count model by this cycle's events.
    always @(negedge clk_i) begin
        if (rst_ni && mon_en) begin
            chk("ready", 32'(req_ready_o), 32'(cyc >= ready_at));
            chk("busy", 32'(busy_o), 32'(cyc < ready_at));
            chk("regid", 32'(hwloop_regid_o), 32'(m_regid));
            chk("start_out", hwloop_start_address_o, m_start);
            chk("end_out", hwloop_end_address_o, m_end);
            chk("cnt_out", hwloop_cnt_data_o, m_cnt);
            mon_we = 3'b000;
            mon_ld = -1;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                mon_it = q.pop_front();
                chk("wr_regid", 32'(hwloop_regid_o), 32'(mon_it.regid));
                case (mon_it.kind)
                    0: begin
                        mon_we = 3'b100;
                        chk("wr_start", hwloop_start_address_o, mon_it.data);
                    end
                    1: begin
                        mon_we = 3'b010;
                        chk("wr_end", hwloop_end_address_o, mon_it.data);
                    end
                    default: begin
                        mon_we = 3'b001;
                        mon_ld = mon_it.regid;
                        chk("wr_cnt", hwloop_cnt_data_o, mon_it.data);
                    end
                endcase
            end
            chk("we", 32'({hwloop_we_start_o, hwloop_we_end_o, hwloop_we_count_o}),
                32'(mon_we));
            for (int l = 0; l < NL; l++) mon_act[l] = (sh[l] != 0);
            chk("active", 32'(loop_active_o), 32'(mon_act));
            for (int l = 0; l < NL; l++) begin
                if (l == mon_ld) sh[l] = mon_it.data;
                else if (hwloop_dec_i[l] && sh[l] != 0) sh[l] = sh[l] - 1;
            end
        end
    end

    task automatic push(input int k, input int rg, input logic [31:0] d, input int c);
        wr_t it;
        it.kind = k;
        it.regid = rg;
        it.data = d;
        it.cyc = c;
        q.push_back(it);
    endtask

    task automatic model_accept(input logic [1:0] op, input int rg, input logic [31:0] pc,
                                input logic [31:0] imm, input logic [31:0] cnt, input int t);
        logic [31:0] tgt;
        tgt = pc + imm;
        m_regid = rg;
        ready_at = t + 2;
        case (op)
            2'd0: begin m_start = tgt; push(0, rg, tgt, t + 1); end
            2'd1: begin m_end = tgt; push(1, rg, tgt, t + 1); end
            2'd2: begin m_cnt = cnt; push(2, rg, cnt, t + 1); end
            default: begin
                m_start = pc + 32'd4;
                m_end = tgt;
                m_cnt = cnt;
                push(0, rg, pc + 32'd4, t + 1);
                push(1, rg, tgt, t + 2);
                push(2, rg, cnt, t + 3);
                ready_at = t + 4;
            end
        endcase
    endtask

    // Holds valid until the model says the sequencer is idle; returns in
    // the cycle after acceptance.
    task automatic issue(input logic [1:0] op, input int rg, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] cnt);
        int t;
        int n;
        req_valid_i = 1'b1;
        req_op_i = op;
        req_regid_i = RB'(rg);
        req_pc_i = pc;
        req_imm_i = imm;
        req_cnt_i = cnt;
        n = 0;
        while (cyc < ready_at && n < 20) begin
            step();
            n++;
        end
        t = cyc;
        step();
        req_valid_i = 1'b0;
        model_accept(op, rg, pc, imm, cnt, t);
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
        if (ready_at > cyc + 1) ready_at = cyc + 1;
        step();
        flush_i = 1'b0;
    endtask

    task automatic drop(input logic [1:0] op, input int rg);
        while (cyc < ready_at) step();
        req_valid_i = 1'b1;
        req_op_i = op;
        req_regid_i = RB'(rg);
        req_pc_i = $urandom;
        req_imm_i = $urandom;
        req_cnt_i = $urandom;
        flush_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        for (int l = 0; l < NL; l++) sh[l] = '0;
        m_regid = 0;
        m_start = '0;
        m_end = '0;
        m_cnt = '0;
        ready_at = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_we"}, 32'({hwloop_we_start_o, hwloop_we_end_o, hwloop_we_count_o}), 32'd0);
        chk({tag, "_active"}, 32'(loop_active_o), 32'd0);
        chk({tag, "_regid"}, 32'(hwloop_regid_o), 32'd0);
        chk({tag, "_start"}, hwloop_start_address_o, 32'd0);
        chk({tag, "_end"}, hwloop_end_address_o, 32'd0);
        chk({tag, "_cnt"}, hwloop_cnt_data_o, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] cnt;
        int          r;

        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset("rst");
        rst_ni = 1'b1;
        mon_en = 1'b1;
        step();

        issue(OP_SETUP, 1, 32'h1000, 32'h40, 32'd5);
        chk("s1_we_start", 32'(hwloop_we_start_o), 32'd1);
        chk("s1_start", hwloop_start_address_o, 32'h1004);
        chk("s1_regid", 32'(hwloop_regid_o), 32'd1);
        step();
        chk("s1_we_end", 32'(hwloop_we_end_o), 32'd1);
        chk("s1_end", hwloop_end_address_o, 32'h1040);
        step();
        chk("s1_we_cnt", 32'(hwloop_we_count_o), 32'd1);
        chk("s1_cnt", hwloop_cnt_data_o, 32'd5);
        step();
        chk("s1_ready", 32'(req_ready_o), 32'd1);
        chk("s1_active", 32'(loop_active_o), 32'b10);

        issue(OP_START, 0, 32'hFFFF_FFF0, 32'h20, 32'd0);
        chk("wrap_we", 32'(hwloop_we_start_o), 32'd1);
        chk("wrap_start", hwloop_start_address_o, 32'h10);
        step();
        chk("wrap_ready", 32'(req_ready_o), 32'd1);

        issue(OP_SETUP, 0, 32'h3000, 32'h80, 32'd2);
        repeat (3) step();
        chk("dec_active0", 32'(loop_active_o), 32'b11);
        for (int i = 0; i < 3; i++) begin
            dec_dir = 2'b01;
            step();
            chk("dec_pulse", 32'(loop_active_o[0]), 32'(i == 0));
        end
        dec_dir = '0;

        issue(OP_COUNT, 0, 32'h0, 32'h0, 32'd7);
        dec_dir = 2'b01;
        step();
        repeat (6) step();
        chk("ldwin_one_left", 32'(loop_active_o[0]), 32'd1);
        step();
        chk("ldwin_zero", 32'(loop_active_o[0]), 32'd0);
        dec_dir = '0;

        issue(OP_SETUP, 0, 32'h2000, 32'h100, 32'd9);
        step();
        chk("fl_we_end", 32'(hwloop_we_end_o), 32'd1);
        do_flush();
        chk("fl_no_cnt", 32'(hwloop_we_count_o), 32'd0);
        chk("fl_idle", 32'(req_ready_o), 32'd1);
        step();
        chk("fl_active", 32'(loop_active_o), 32'b10);

        issue(OP_SETUP, 1, 32'h4000, 32'h200, 32'd3);
        issue(OP_COUNT, 0, 32'h0, 32'h0, 32'd4);
        step();

        drop(OP_SETUP, 0);
        chk("drop_we", 32'({hwloop_we_start_o, hwloop_we_end_o, hwloop_we_count_o}), 32'd0);
        chk("drop_ready", 32'(req_ready_o), 32'd1);

        dec_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 3);
            cnt = (r == 0) ? 32'd0 : (r < 3) ? 32'($urandom_range(1, 3)) : $urandom;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                drop(op, $urandom_range(0, NL - 1));
            end else begin
                issue(op, $urandom_range(0, NL - 1), $urandom, $urandom, cnt);
                if (r <= 2) begin
                    repeat ($urandom_range(0, 3)) step();
                    do_flush();
                end else if (r >= 6) begin
                    repeat ($urandom_range(0, 3)) step();
                end
            end
        end
        dec_en = 1'b0;
        repeat (6) step();

        issue(OP_SETUP, 1, 32'h5000, 32'h60, 32'd8);
        step();
        rst_ni = 1'b0;
        #1;
        chk_reset("arst");
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step();
        issue(OP_END, 1, 32'h6000, 32'h10, 32'd0);
        chk("post_end", hwloop_end_address_o, 32'h6010);
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
